// File: rtl/fnd_mode_ctrl.sv
// Display/button arbiter for one shared 4-digit FND between watch, cook timer and stopwatch.
// A mode button cycles the sources behind a short banner; a ringing cook-timer alarm pre-empts everything.
module fnd_mode_ctrl #(
  parameter int BANNER_CYCLES = 50_000_000,
  parameter int BLINK_HALF    = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn_mode,
  input  logic [2:0]  btn_in,
  input  logic        alarm,
  input  logic [15:0] watch_value,
  input  logic [15:0] timer_value,
  input  logic [15:0] stop_value,
  output logic [15:0] fnd_value,
  output logic        fnd_blank,
  output logic [1:0]  mode,
  output logic [2:0]  watch_btn,
  output logic [2:0]  timer_btn,
  output logic [2:0]  stop_btn,
  output logic        alarm_off
);

  typedef enum logic [1:0] {SHOW, BANNER, ALARM} state_t;

  localparam int BNW = (BANNER_CYCLES > 1) ? $clog2(BANNER_CYCLES) : 1;
  localparam int BKW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BNW-1:0] BANNER_LAST = BNW'(BANNER_CYCLES - 1);
  localparam logic [BKW-1:0] BLINK_LAST  = BKW'(BLINK_HALF - 1);

  state_t         state;
  logic [BNW-1:0] banner_cnt;
  logic [BKW-1:0] blink_cnt;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return (m == 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

  function automatic logic [15:0] banner_value(input logic [1:0] m);
    return {12'hF00, 2'b00, m};
  endfunction

  function automatic logic [15:0] source_value(input logic [1:0] m, input logic [15:0] w,
                                               input logic [15:0] t, input logic [15:0] s);
    case (m)
      2'd1:    return t;
      2'd2:    return s;
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= SHOW;
      mode       <= 2'd0;
      fnd_value  <= 16'h0000;
      fnd_blank  <= 1'b0;
      watch_btn  <= 3'b000;
      timer_btn  <= 3'b000;
      stop_btn   <= 3'b000;
      alarm_off  <= 1'b0;
      banner_cnt <= '0;
      blink_cnt  <= '0;
    end else begin
      // Button outputs are pulses: default low, raised only on the routing cycle.
      watch_btn <= 3'b000;
      timer_btn <= 3'b000;
      stop_btn  <= 3'b000;
      alarm_off <= 1'b0;
      case (state)
        ALARM: begin
          fnd_value <= timer_value;
          if (!alarm) begin
            state     <= SHOW;
            mode      <= 2'd1;
            fnd_blank <= 1'b0;
          end else begin
            alarm_off <= |btn_in;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              fnd_blank <= ~fnd_blank;
            end else begin
              blink_cnt <= blink_cnt + BKW'(1);
            end
          end
        end
        default: begin
          fnd_blank <= 1'b0;
          if (alarm) begin
            state     <= ALARM;
            blink_cnt <= '0;
            fnd_value <= timer_value;
          end else if (btn_mode) begin
            state      <= BANNER;
            mode       <= next_mode(mode);
            banner_cnt <= '0;
            fnd_value  <= banner_value(next_mode(mode));
          end else if (state == BANNER) begin
            if (banner_cnt == BANNER_LAST) begin
              state      <= SHOW;
              banner_cnt <= '0;
              fnd_value  <= source_value(mode, watch_value, timer_value, stop_value);
            end else begin
              banner_cnt <= banner_cnt + BNW'(1);
              fnd_value  <= banner_value(mode);
            end
          end else begin
            fnd_value <= source_value(mode, watch_value, timer_value, stop_value);
            case (mode)
              2'd1:    timer_btn <= btn_in;
              2'd2:    stop_btn  <= btn_in;
              default: watch_btn <= btn_in;
            endcase
          end
        end
      endcase
    end
  end

endmodule
